// File: rtl/disp_pkg.sv
// Shared constants and types for the SPI display command decoder.
// The GET_CSUM state only exists when DISP_CSUM_EN is defined.
package disp_pkg;

  localparam logic [7:0] CMD_WRITE = 8'hA1;
  localparam logic [7:0] CMD_INC   = 8'hA2;
  localparam logic [7:0] CMD_CLEAR = 8'hA3;

  typedef logic [7:0] err_cnt_t;

`ifdef DISP_CSUM_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_HI   = 2'd1,
    GET_LO   = 2'd2,
    GET_CSUM = 2'd3
  } disp_state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2
  } disp_state_t;
`endif

endpackage

// File: rtl/frame_timer.sv
// Inter-byte watchdog: counts idle cycles while a frame is open and flags
// expiry once TIMEOUT_CYCLES cycles have passed without a kick.
module frame_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam logic [23:0] LIMIT = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] count;

  // Saturates at LIMIT so a stalled decoder cannot wrap back to "fresh".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || kick) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 24'd1;
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/disp_cmd_decoder.sv
// Decodes the STM32 SPI byte stream into seven-segment display updates.
// Define DISP_CSUM_EN to require a trailing XOR checksum byte on every command.
module disp_cmd_decoder
  import disp_pkg::*;
#(
  parameter int unsigned  TIMEOUT_CYCLES = 1_000_000,
  parameter logic [15:0]  RESET_VALUE    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [15:0] number,
  output logic        update,
  output logic        frame_err,
  output err_cnt_t    err_count,
  output logic        busy
);

  disp_state_t state, state_n;
  logic [7:0]  hi_q, hi_n;
  logic [15:0] number_n;
  logic        update_n, err_n;
  logic        byte_ok, expired;

`ifdef DISP_CSUM_EN
  logic [7:0]  lo_q, lo_n, cmd_q, cmd_n, csum_q, csum_n;
`endif

  assign byte_ok = rx_valid && !cs_n;

  frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (state != IDLE),
    .kick    (byte_ok),
    .expired (expired)
  );

  // Priority: chip-select abort, then an accepted byte, then timeout.
  always_comb begin
    state_n  = state;
    hi_n     = hi_q;
    number_n = number;
    update_n = 1'b0;
    err_n    = 1'b0;
`ifdef DISP_CSUM_EN
    lo_n     = lo_q;
    cmd_n    = cmd_q;
    csum_n   = csum_q;
`endif
    if (cs_n && state != IDLE) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end else if (byte_ok) begin
      case (state)
`ifdef DISP_CSUM_EN
        IDLE: begin
          cmd_n  = rx_data;
          csum_n = rx_data;
          if (rx_data == CMD_WRITE) state_n = GET_HI;
          else if (rx_data == CMD_INC || rx_data == CMD_CLEAR) state_n = GET_CSUM;
          else err_n = 1'b1;
        end
        GET_HI: begin
          hi_n    = rx_data;
          csum_n  = csum_q ^ rx_data;
          state_n = GET_LO;
        end
        GET_LO: begin
          lo_n    = rx_data;
          csum_n  = csum_q ^ rx_data;
          state_n = GET_CSUM;
        end
        GET_CSUM: begin
          state_n = IDLE;
          if (rx_data == csum_q) begin
            update_n = 1'b1;
            if (cmd_q == CMD_WRITE)    number_n = {hi_q, lo_q};
            else if (cmd_q == CMD_INC) number_n = number + 16'd1;
            else                       number_n = RESET_VALUE;
          end else begin
            err_n = 1'b1;
          end
        end
`else
        IDLE: begin
          if (rx_data == CMD_WRITE) begin
            state_n = GET_HI;
          end else if (rx_data == CMD_INC) begin
            number_n = number + 16'd1;
            update_n = 1'b1;
          end else if (rx_data == CMD_CLEAR) begin
            number_n = RESET_VALUE;
            update_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
        GET_HI: begin
          hi_n    = rx_data;
          state_n = GET_LO;
        end
        GET_LO: begin
          number_n = {hi_q, rx_data};
          update_n = 1'b1;
          state_n  = IDLE;
        end
`endif
        default: state_n = IDLE;
      endcase
    end else if (expired) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      hi_q      <= '0;
      number    <= RESET_VALUE;
      update    <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
      busy      <= 1'b0;
`ifdef DISP_CSUM_EN
      lo_q      <= '0;
      cmd_q     <= '0;
      csum_q    <= '0;
`endif
    end else begin
      state     <= state_n;
      hi_q      <= hi_n;
      number    <= number_n;
      update    <= update_n;
      frame_err <= err_n;
      busy      <= (state_n != IDLE);
      if (err_n && err_count != 8'hFF) err_count <= err_count + 8'd1;
`ifdef DISP_CSUM_EN
      lo_q      <= lo_n;
      cmd_q     <= cmd_n;
      csum_q    <= csum_n;
`endif
    end
  end

endmodule
